ecc_result_unloader: RTL and testbench

- Output-side counterpart of the ECC top-level nibble loader, which packs 4-bit input nibbles LSB-first into 32-bit words over 8 cycles.
- This block captures the two 32-bit final result words (kP x, kP y) when the Control block asserts all_done.
- It then streams them out LSB-first as sixteen 4-bit nibbles over a valid/ready handshake, all x nibbles before any y nibbles.
- Sits between Control (output_1, output_2, all_done) and the narrow chip output pins.

---
 rtl/ecc_pkg.sv | 16 +
 rtl/ecc_nibble_piso.sv | 34 +++
 rtl/ecc_result_unloader.sv | 123 ++++++++++++
 tb/tb_ecc_result_unloader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared constants and unloader state encoding for the ECC datapath
package ecc_pkg;

    localparam int SIZE          = 32;
    localparam int NIB_W         = 4;
    localparam int NIBS_PER_WORD = SIZE / NIB_W;
    localparam int CNT_W         = $clog2(NIBS_PER_WORD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_X = 2'd1,
        SEND_Y = 2'd2,
        DONE   = 2'd3
    } unl_state_t;

endpackage

// File: rtl/ecc_nibble_piso.sv
// rtl/ecc_nibble_piso.sv - parallel-load register that shifts right one nibble per shift enable
module ecc_nibble_piso
    import ecc_pkg::*;
#(
    parameter int W  = SIZE,
    parameter int NW = NIB_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  logic          shift,
    input  logic [W-1:0]  d,
    output logic [NW-1:0] nib
);

    logic [W-1:0] sh;

    // clear outranks load so an abort always leaves the register empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh <= '0;
        end else if (clear) begin
            sh <= '0;
        end else if (load) begin
            sh <= d;
        end else if (shift) begin
            sh <= {{NW{1'b0}}, sh[W-1:NW]};
        end
    end

    assign nib = sh[NW-1:0];

endmodule

// File: rtl/ecc_result_unloader.sv
// rtl/ecc_result_unloader.sv - captures kP x/y result words and streams them out LSB-first as nibbles
module ecc_result_unloader #(
    parameter int SIZE  = 32,
    parameter int NIB_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_done,
    input  logic [SIZE-1:0]  i_out_x,
    input  logic [SIZE-1:0]  i_out_y,
    input  logic             i_flush,
    input  logic             i_ready,
    output logic [NIB_W-1:0] o_nibble,
    output logic             o_valid,
    output logic             o_sel_y,
    output logic             o_first,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overrun
);

    import ecc_pkg::*;

    localparam int NIBS = SIZE / NIB_W;
    localparam int CW   = $clog2(NIBS);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIBS - 1);

    unl_state_t       state;
    logic [CW-1:0]    cnt;
    logic             overrun_q;
    logic [NIB_W-1:0] nib_x;
    logic [NIB_W-1:0] nib_y;
    logic             load;
    logic             shift_x;
    logic             shift_y;

    assign load    = (state == IDLE) && i_done && !i_flush;
    assign shift_x = (state == SEND_X) && i_ready;
    assign shift_y = (state == SEND_Y) && i_ready;

    ecc_nibble_piso #(.W(SIZE), .NW(NIB_W)) u_piso_x (
        .clk   (i_clk),
        .rst   (i_rst),
        .clear (i_flush),
        .load  (load),
        .shift (shift_x),
        .d     (i_out_x),
        .nib   (nib_x)
    );

    ecc_nibble_piso #(.W(SIZE), .NW(NIB_W)) u_piso_y (
        .clk   (i_clk),
        .rst   (i_rst),
        .clear (i_flush),
        .load  (load),
        .shift (shift_y),
        .d     (i_out_y),
        .nib   (nib_y)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            overrun_q <= 1'b0;
        end else begin
            // a done dropped by a same-cycle flush is not an overrun
            overrun_q <= i_done && !i_flush && (state != IDLE);
            if (i_flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_done) begin
                            state <= SEND_X;
                            cnt   <= '0;
                        end
                    end
                    SEND_X: begin
                        if (i_ready) begin
                            if (cnt == CNT_LAST) begin
                                state <= SEND_Y;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    SEND_Y: begin
                        if (i_ready) begin
                            if (cnt == CNT_LAST) begin
                                state <= DONE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // stream flags decode from state and cnt only, never from i_ready
    assign o_valid   = (state == SEND_X) || (state == SEND_Y);
    assign o_sel_y   = (state == SEND_Y);
    assign o_first   = (state == SEND_X) && (cnt == '0);
    assign o_last    = (state == SEND_Y) && (cnt == CNT_LAST);
    assign o_busy    = (state != IDLE);
    assign o_done    = (state == DONE);
    assign o_overrun = overrun_q;
    assign o_nibble  = (state == SEND_X) ? nib_x :
                       (state == SEND_Y) ? nib_y : '0;

endmodule

// File: tb/tb_ecc_result_unloader.sv
// tb/tb_ecc_result_unloader.sv - scoreboard bench for ecc_result_unloader
module tb_ecc_result_unloader;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_done = 1'b0;
    logic [31:0] i_out_x = '0;
    logic [31:0] i_out_y = '0;
    logic        i_flush = 1'b0;
    logic        i_ready = 1'b1;
    logic [3:0]  o_nibble;
    logic        o_valid, o_sel_y, o_first, o_last, o_busy, o_done, o_overrun;

    typedef struct packed {
        logic [3:0] nib;
        logic       sel_y;
        logic       first;
        logic       last;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   passed = 0;
    int   total  = 0;
    logic [3:0] basic_tab [16];

    ecc_result_unloader #(.SIZE(32), .NIB_W(4)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_done    (i_done),
        .i_out_x   (i_out_x),
        .i_out_y   (i_out_y),
        .i_flush   (i_flush),
        .i_ready   (i_ready),
        .o_nibble  (o_nibble),
        .o_valid   (o_valid),
        .o_sel_y   (o_sel_y),
        .o_first   (o_first),
        .o_last    (o_last),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_overrun (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic push_stream(input logic [31:0] x, input logic [31:0] y);
        for (int i = 0; i < 8; i++)
            sb.push_back(exp_t'{nib: x[i*4 +: 4], sel_y: 1'b0, first: (i == 0), last: 1'b0});
        for (int i = 0; i < 8; i++)
            sb.push_back(exp_t'{nib: y[i*4 +: 4], sel_y: 1'b1, first: 1'b0, last: (i == 7)});
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    // monitor: every presented-and-accepted nibble must match the scoreboard head
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", {31'b0, o_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("nibble", {28'b0, o_nibble}, {28'b0, e.nib});
                chk("sel_y",  {31'b0, o_sel_y},  {31'b0, e.sel_y});
                chk("first",  {31'b0, o_first},  {31'b0, e.first});
                chk("last",   {31'b0, o_last},   {31'b0, e.last});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        basic_tab = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1,
                      4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9};

        // reset state
        #12;
        chk("rst_valid", {31'b0, o_valid}, 0);
        chk("rst_busy",  {31'b0, o_busy}, 0);
        chk("rst_done",  {31'b0, o_done}, 0);
        chk("rst_nib",   {28'b0, o_nibble}, 0);
        next_cycle();
        i_rst = 1'b0;
        next_cycle();

        // basic stream
        for (int c = 0; c <= 18; c++) begin
            i_done = (c == 0);
            if (c == 0) begin
                i_out_x = 32'h12345678;
                i_out_y = 32'h9ABCDEF0;
                for (int i = 0; i < 16; i++)
                    sb.push_back(exp_t'{nib: basic_tab[i], sel_y: (i >= 8), first: (i == 0), last: (i == 15)});
            end
            @(negedge i_clk);
            if (c == 1)  chk("basic_first_c1", {31'b0, o_first}, 1);
            if (c == 8)  chk("basic_sel_y_c8", {31'b0, o_sel_y}, 0);
            if (c == 9)  chk("basic_sel_y_c9", {31'b0, o_sel_y}, 1);
            if (c == 16) chk("basic_done_c16", {31'b0, o_done}, 0);
            if (c == 17) chk("basic_done_c17", {31'b0, o_done}, 1);
            if (c == 17) chk("basic_valid_c17", {31'b0, o_valid}, 0);
            if (c == 18) chk("basic_busy_c18", {31'b0, o_busy}, 0);
            next_cycle();
        end
        i_done = 1'b0;
        next_cycle();

        // backpressure in cycles 3..5
        for (int c = 0; c <= 21; c++) begin
            i_done  = (c == 0);
            i_ready = !(c >= 3 && c <= 5);
            if (c == 0) push_stream(32'h12345678, 32'h9ABCDEF0);
            @(negedge i_clk);
            if (c >= 3 && c <= 6) begin
                chk($sformatf("bp_hold_nib_c%0d", c), {28'b0, o_nibble}, 32'h6);
                chk($sformatf("bp_hold_valid_c%0d", c), {31'b0, o_valid}, 1);
            end
            if (c == 18) chk("bp_last_c18", {31'b0, o_last}, 0);
            if (c == 19) chk("bp_last_c19", {31'b0, o_last}, 1);
            if (c == 20) chk("bp_done_c20", {31'b0, o_done}, 1);
            next_cycle();
        end
        i_ready = 1'b1;
        i_done  = 1'b0;
        next_cycle();

        // overrun at cycle 5
        for (int c = 0; c <= 18; c++) begin
            i_done = (c == 0) || (c == 5);
            if (c == 0) begin
                i_out_x = 32'h12345678;
                i_out_y = 32'h9ABCDEF0;
                push_stream(32'h12345678, 32'h9ABCDEF0);
            end
            if (c == 5) begin
                i_out_x = 32'hAAAAAAAA;
                i_out_y = 32'h0;
            end
            @(negedge i_clk);
            if (c == 5) chk("ovr_c5", {31'b0, o_overrun}, 0);
            if (c == 6) chk("ovr_c6", {31'b0, o_overrun}, 1);
            if (c == 7) chk("ovr_c7", {31'b0, o_overrun}, 0);
            if (c == 17) chk("ovr_done_c17", {31'b0, o_done}, 1);
            next_cycle();
        end
        i_done = 1'b0;
        next_cycle();

        // flush at cycle 10, restart at cycle 12
        for (int c = 0; c <= 31; c++) begin
            i_done  = (c == 0) || (c == 12);
            i_flush = (c == 10);
            if (c == 0) begin
                i_out_x = 32'h12345678;
                i_out_y = 32'h9ABCDEF0;
                push_stream(32'h12345678, 32'h9ABCDEF0);
            end
            if (c == 11) sb.delete();
            if (c == 12) begin
                i_out_x = 32'h0000000F;
                i_out_y = 32'h0;
                push_stream(32'h0000000F, 32'h0);
            end
            @(negedge i_clk);
            if (c == 11) begin
                chk("flush_valid_c11", {31'b0, o_valid}, 0);
                chk("flush_busy_c11", {31'b0, o_busy}, 0);
            end
            if (c >= 11) chk($sformatf("flush_done_c%0d", c), {31'b0, o_done}, {31'b0, (c == 29)});
            if (c == 13) chk("flush_restart_nib_c13", {28'b0, o_nibble}, 32'hF);
            next_cycle();
        end
        i_done = 1'b0;
        i_flush = 1'b0;
        next_cycle();

        // async reset mid-SEND_Y
        i_out_x = 32'h12345678;
        i_out_y = 32'h9ABCDEF0;
        for (int c = 0; c <= 12; c++) begin
            i_done = (c == 0);
            if (c == 0) push_stream(32'h12345678, 32'h9ABCDEF0);
            if (c < 12) next_cycle();
        end
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_nib",     {28'b0, o_nibble}, 0);
        chk("arst_valid",   {31'b0, o_valid}, 0);
        chk("arst_sel_y",   {31'b0, o_sel_y}, 0);
        chk("arst_first",   {31'b0, o_first}, 0);
        chk("arst_last",    {31'b0, o_last}, 0);
        chk("arst_busy",    {31'b0, o_busy}, 0);
        chk("arst_done",    {31'b0, o_done}, 0);
        chk("arst_overrun", {31'b0, o_overrun}, 0);
        sb.delete();
        next_cycle();
        i_rst = 1'b0;
        next_cycle();
        for (int c = 0; c <= 18; c++) begin
            i_done = (c == 0);
            if (c == 0) begin
                i_out_x = 32'hCAFEF00D;
                i_out_y = 32'h01234567;
                push_stream(32'hCAFEF00D, 32'h01234567);
            end
            @(negedge i_clk);
            chk($sformatf("arst_ovr_c%0d", c), {31'b0, o_overrun}, 0);
            if (c == 17) chk("arst_done_c17", {31'b0, o_done}, 1);
            next_cycle();
        end
        i_done = 1'b0;
        next_cycle();

        // back-to-back: done in DONE state is overrun, done in IDLE is accepted
        for (int c = 0; c <= 37; c++) begin
            i_done = (c == 0) || (c == 17) || (c == 18);
            if (c == 0) begin
                i_out_x = 32'h12345678;
                i_out_y = 32'h9ABCDEF0;
                push_stream(32'h12345678, 32'h9ABCDEF0);
            end
            if (c == 17) begin
                i_out_x = 32'hAAAAAAAA;
                i_out_y = 32'hAAAAAAAA;
            end
            if (c == 18) begin
                i_out_x = 32'h13579BDF;
                i_out_y = 32'h2468ACE0;
                push_stream(32'h13579BDF, 32'h2468ACE0);
            end
            @(negedge i_clk);
            if (c == 17) chk("b2b_ovr_c17", {31'b0, o_overrun}, 0);
            if (c == 18) chk("b2b_ovr_c18", {31'b0, o_overrun}, 1);
            if (c == 19) begin
                chk("b2b_valid_c19", {31'b0, o_valid}, 1);
                chk("b2b_first_c19", {31'b0, o_first}, 1);
                chk("b2b_ovr_c19", {31'b0, o_overrun}, 0);
            end
            if (c == 35) chk("b2b_done_c35", {31'b0, o_done}, 1);
            if (c == 37) chk("b2b_busy_c37", {31'b0, o_busy}, 0);
            next_cycle();
        end
        i_done = 1'b0;
        next_cycle();

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
